// File: rtl/sr_pulse_driver.sv
// Command-side driver for a bank of set/reset storage cells: accepts set/clear commands,
// emits one width-controlled s/r pulse with enable, enforces a hold-off gap, tracks a shadow state.
module sr_pulse_driver #(
    parameter int N_CH           = 4,
    parameter int PULSE_W        = 4,
    parameter int GAP_W          = 2,
    parameter int SKIP_REDUNDANT = 1,
    localparam int IDX_W         = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [IDX_W-1:0] cmd_idx,
    input  logic             cmd_set,
    output logic [N_CH-1:0]  s_o,
    output logic [N_CH-1:0]  r_o,
    output logic [N_CH-1:0]  en_o,
    output logic [N_CH-1:0]  shadow_o,
    output logic             busy,
    output logic             done,
    output logic             err
);

    localparam int PG_MAX  = (PULSE_W > GAP_W) ? PULSE_W : GAP_W;
    localparam int CNT_MAX = (PG_MAX > 1) ? PG_MAX : 1;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    typedef enum logic [1:0] {
        IDLE,
        PULSE,
        GAP
    } state_t;

    state_t            state_reg;
    logic [CNT_W-1:0]  cnt_reg;
    logic [N_CH-1:0]   s_reg;
    logic [N_CH-1:0]   r_reg;
    logic [N_CH-1:0]   en_reg;
    logic [N_CH-1:0]   shadow_reg;
    logic              busy_reg;
    logic              done_reg;
    logic              err_reg;

    // One-hot decode of the requested channel; all-zero means the index is out of range.
    logic [N_CH-1:0]   sel;
    logic              in_range;
    logic              redundant;

    generate
        for (genvar gi = 0; gi < N_CH; gi++) begin : g_dec
            assign sel[gi] = (cmd_idx == IDX_W'(gi));
        end
    endgenerate

    assign in_range  = |sel;
    assign redundant = ((|(shadow_reg & sel)) == cmd_set);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg  <= IDLE;
            cnt_reg    <= '0;
            s_reg      <= '0;
            r_reg      <= '0;
            en_reg     <= '0;
            shadow_reg <= '0;
            busy_reg   <= 1'b0;
            done_reg   <= 1'b0;
            err_reg    <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            err_reg  <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (cmd_valid) begin
                        if (!in_range) begin
                            err_reg <= 1'b1;
                        end else if ((SKIP_REDUNDANT != 0) && redundant) begin
                            done_reg <= 1'b1;
                        end else begin
                            // Only one of s/r is ever loaded, so 2'b11 cannot reach a cell.
                            state_reg  <= PULSE;
                            cnt_reg    <= CNT_W'(PULSE_W - 1);
                            s_reg      <= cmd_set ? sel : '0;
                            r_reg      <= cmd_set ? '0 : sel;
                            en_reg     <= sel;
                            shadow_reg <= cmd_set ? (shadow_reg | sel) : (shadow_reg & ~sel);
                            busy_reg   <= 1'b1;
                        end
                    end
                end
                PULSE: begin
                    if (cnt_reg == '0) begin
                        s_reg  <= '0;
                        r_reg  <= '0;
                        en_reg <= '0;
                        if (GAP_W == 0) begin
                            state_reg <= IDLE;
                            busy_reg  <= 1'b0;
                            done_reg  <= 1'b1;
                        end else begin
                            state_reg <= GAP;
                            cnt_reg   <= CNT_W'(GAP_W - 1);
                        end
                    end else begin
                        cnt_reg <= cnt_reg - 1'b1;
                    end
                end
                GAP: begin
                    if (cnt_reg == '0) begin
                        state_reg <= IDLE;
                        busy_reg  <= 1'b0;
                        done_reg  <= 1'b1;
                    end else begin
                        cnt_reg <= cnt_reg - 1'b1;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    s_reg     <= '0;
                    r_reg     <= '0;
                    en_reg    <= '0;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign cmd_ready = (state_reg == IDLE);
    assign s_o       = s_reg;
    assign r_o       = r_reg;
    assign en_o      = en_reg;
    assign shadow_o  = shadow_reg;
    assign busy      = busy_reg;
    assign done      = done_reg;
    assign err       = err_reg;

endmodule

// File: tb/tb_sr_pulse_driver.sv
// Bench for sr_pulse_driver: table of commands scored through an event queue, plus hand
// sequences for no-skip mode, an out-of-range index on a 3-channel build, and reset mid-pulse.
module tb_sr_pulse_driver;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Main DUT: default parameters
    logic       cmd_valid = 1'b0, cmd_set = 1'b0, cmd_ready, busy, done, err;
    logic [1:0] cmd_idx = '0;
    logic [3:0] s_o, r_o, en_o, shadow_o;

    sr_pulse_driver #(.N_CH(4), .PULSE_W(4), .GAP_W(2), .SKIP_REDUNDANT(1)) u_dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_idx(cmd_idx), .cmd_set(cmd_set), .s_o(s_o), .r_o(r_o), .en_o(en_o),
        .shadow_o(shadow_o), .busy(busy), .done(done), .err(err)
    );

    // Redundant commands still pulse
    logic       v2 = 1'b0, st2 = 1'b0, ready2, busy2, done2, err2;
    logic [1:0] i2 = '0;
    logic [3:0] s2, r2, en2, sh2;

    sr_pulse_driver #(.N_CH(4), .PULSE_W(4), .GAP_W(2), .SKIP_REDUNDANT(0)) u_noskip (
        .clk(clk), .reset(reset), .cmd_valid(v2), .cmd_ready(ready2),
        .cmd_idx(i2), .cmd_set(st2), .s_o(s2), .r_o(r2), .en_o(en2),
        .shadow_o(sh2), .busy(busy2), .done(done2), .err(err2)
    );

    // Three channels, so index 3 is out of range
    logic       v3 = 1'b0, st3 = 1'b0, ready3, busy3, done3, err3;
    logic [1:0] i3 = '0;
    logic [2:0] s3, r3, en3, sh3;

    sr_pulse_driver #(.N_CH(3), .PULSE_W(4), .GAP_W(2), .SKIP_REDUNDANT(1)) u_n3 (
        .clk(clk), .reset(reset), .cmd_valid(v3), .cmd_ready(ready3),
        .cmd_idx(i3), .cmd_set(st3), .s_o(s3), .r_o(r3), .en_o(en3),
        .shadow_o(sh3), .busy(busy3), .done(done3), .err(err3)
    );

    // Expected observable events: 0 = pulse start, 1 = done strobe, 2 = err strobe
    typedef struct {
        int         kind;
        int         cyc;
        logic [3:0] s;
        logic [3:0] r;
        logic [3:0] sh;
    } ev_t;
    ev_t sbq[$];

    typedef struct {
        logic [1:0] idx;
        logic       set;
        int         kind;   // 0 = pulsed, 1 = redundant skip
        logic [3:0] s;
        logic [3:0] r;
        logic [3:0] sh;
    } vec_t;
    vec_t tbl[6];

    bit         sb_on = 1'b0;
    logic [3:0] en_prev = '0;
    int         plen = 0;

    always @(negedge clk) begin
        ev_t e;
        chk("s_and_r_zero", 32'(s_o & r_o), 32'd0);
        chk("en_eq_s_or_r", 32'(en_o), 32'(s_o | r_o));
        chk("en_onehot0", 32'($countones(en_o) <= 1), 32'd1);
        chk("err_done_excl", 32'(err & done), 32'd0);
        if (sb_on) begin
            if (en_o != 4'b0 && en_prev == 4'b0) begin
                plen = 0;
                if (sbq.size() == 0) begin
                    chk("unexpected_pulse", 32'(en_o), 32'd0);
                end else begin
                    e = sbq.pop_front();
                    chk("pulse_kind", 32'(e.kind), 32'd0);
                    chk("pulse_cycle", 32'(cyc), 32'(e.cyc));
                    chk("pulse_s", 32'(s_o), 32'(e.s));
                    chk("pulse_r", 32'(r_o), 32'(e.r));
                    chk("pulse_shadow", 32'(shadow_o), 32'(e.sh));
                end
            end
            if (en_o != 4'b0) plen++;
            if (en_o == 4'b0 && en_prev != 4'b0) chk("pulse_len", 32'(plen), 32'd4);
            if (done) begin
                if (sbq.size() == 0) begin
                    chk("unexpected_done", 32'(done), 32'd0);
                end else begin
                    e = sbq.pop_front();
                    chk("done_kind", 32'(e.kind), 32'd1);
                    chk("done_cycle", 32'(cyc), 32'(e.cyc));
                    chk("done_shadow", 32'(shadow_o), 32'(e.sh));
                end
            end
            if (err) chk("unexpected_err", 32'(err), 32'd0);
        end
        en_prev = en_o;
    end

    initial begin
        int a, prev_a, prev_kind, n, cnt;
        bit saw;

        tbl[0] = '{2'd2, 1'b1, 0, 4'b0100, 4'b0000, 4'b0100};
        tbl[1] = '{2'd2, 1'b1, 1, 4'b0000, 4'b0000, 4'b0100};
        tbl[2] = '{2'd0, 1'b1, 0, 4'b0001, 4'b0000, 4'b0101};
        tbl[3] = '{2'd0, 1'b0, 0, 4'b0000, 4'b0001, 4'b0100};
        tbl[4] = '{2'd1, 1'b1, 0, 4'b0010, 4'b0000, 4'b0110};
        tbl[5] = '{2'd3, 1'b0, 1, 4'b0000, 4'b0000, 4'b0110};

        // Reset, then three idle cycles
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_ready", 32'(cmd_ready), 32'd1);
        chk("rst_shadow", 32'(shadow_o), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_s", 32'(s_o), 32'd0);
        chk("rst_r", 32'(r_o), 32'd0);
        chk("rst_en", 32'(en_o), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_ready_noskip", 32'(ready2), 32'd1);
        chk("rst_ready_n3", 32'(ready3), 32'd1);

        // Table with cmd_valid held high: each command goes in as soon as the block is ready
        sb_on = 1'b1;
        prev_a = 0;
        prev_kind = 0;
        for (int i = 0; i < 6; i++) begin
            n = 0;
            while (!cmd_ready && n < 40) begin
                @(negedge clk);
                n++;
            end
            if (!cmd_ready) begin
                chk("ready_timeout", 32'(cmd_ready), 32'd1);
                break;
            end
            cmd_valid = 1'b1;
            cmd_idx   = tbl[i].idx;
            cmd_set   = tbl[i].set;
            a = cyc + 1;
            if (tbl[i].kind == 0) begin
                sbq.push_back('{0, a, tbl[i].s, tbl[i].r, tbl[i].sh});
                sbq.push_back('{1, a + 6, 4'b0, 4'b0, tbl[i].sh});
            end else begin
                sbq.push_back('{1, a, 4'b0, 4'b0, tbl[i].sh});
            end
            if (i > 0) chk("accept_spacing", 32'(a - prev_a), (prev_kind == 0) ? 32'd7 : 32'd1);
            $display("txn %0d: idx=%0d set=%0d kind=%0d accepted_cycle=%0d", i, tbl[i].idx,
                     tbl[i].set, tbl[i].kind, a);
            prev_a = a;
            prev_kind = tbl[i].kind;
            @(negedge clk);
            if (tbl[i].kind == 1) begin
                chk("skip_busy", 32'(busy), 32'd0);
                chk("skip_no_pulse", 32'(en_o), 32'd0);
            end
        end
        cmd_valid = 1'b0;
        repeat (10) @(negedge clk);
        chk("scoreboard_drained", 32'(sbq.size()), 32'd0);

        // No-skip build: repeating idx 2 set still produces a full pulse
        v2 = 1'b1; i2 = 2'd2; st2 = 1'b1;
        @(negedge clk);
        v2 = 1'b0;
        n = 0;
        while (!done2 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("ns_first_done", 32'(done2), 32'd1);
        v2 = 1'b1;
        @(negedge clk);
        v2 = 1'b0;
        $display("txn noskip: idx=2 set=1 repeated, accepted_cycle=%0d", cyc);
        cnt = 0;
        saw = 1'b0;
        for (int k = 0; k < 10; k++) begin
            if (s2 == 4'b0100 && en2 == 4'b0100 && r2 == 4'b0000) cnt++;
            if (done2) saw = 1'b1;
            @(negedge clk);
        end
        chk("ns_repeat_pulse_len", 32'(cnt), 32'd4);
        chk("ns_repeat_done", 32'(saw), 32'd1);
        chk("ns_shadow", 32'(sh2), 32'b0100);

        // Three-channel build: set idx 1, then an out-of-range idx 3
        v3 = 1'b1; i3 = 2'd1; st3 = 1'b1;
        @(negedge clk);
        v3 = 1'b0;
        n = 0;
        while (!done3 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("n3_first_done", 32'(done3), 32'd1);
        chk("n3_shadow_set", 32'(sh3), 32'b010);
        v3 = 1'b1; i3 = 2'd3; st3 = 1'b1;
        @(negedge clk);
        v3 = 1'b0;
        $display("txn n3: idx=3 set=1 out of range, cycle=%0d", cyc);
        chk("n3_err", 32'(err3), 32'd1);
        chk("n3_err_no_done", 32'(done3), 32'd0);
        chk("n3_err_shadow", 32'(sh3), 32'b010);
        chk("n3_err_s", 32'(s3), 32'd0);
        chk("n3_err_r", 32'(r3), 32'd0);
        chk("n3_err_busy", 32'(busy3), 32'd0);
        @(negedge clk);
        chk("n3_err_one_cycle", 32'(err3), 32'd0);
        chk("n3_err_no_pulse", 32'(en3), 32'd0);

        // Reset in the second pulse cycle of idx 1 clear aborts with no done
        sb_on = 1'b0;
        cmd_valid = 1'b1; cmd_idx = 2'd1; cmd_set = 1'b0;
        @(negedge clk);
        cmd_valid = 1'b0;
        $display("txn abort: idx=1 set=0 accepted_cycle=%0d", cyc);
        chk("abort_pulse_r", 32'(r_o), 32'b0010);
        chk("abort_pulse_en", 32'(en_o), 32'b0010);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("abort_r", 32'(r_o), 32'd0);
        chk("abort_en", 32'(en_o), 32'd0);
        chk("abort_s", 32'(s_o), 32'd0);
        chk("abort_shadow", 32'(shadow_o), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("abort_ready", 32'(cmd_ready), 32'd1);
        saw = 1'b0;
        for (int k = 0; k < 8; k++) begin
            if (done) saw = 1'b1;
            @(negedge clk);
        end
        chk("abort_no_done", 32'(saw), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sr_pulse_driver.md
Name: sr_pulse_driver

Overview:
- Command-side driver for a bank of set/reset storage elements (SR flip-flops, latching relays, sticky flag cells).
- Accepts set/clear commands over a valid/ready handshake.
- Generates a single, width-controlled set or reset pulse, with enable, on the addressed channel.
- Enforces a hold-off gap between commands and keeps a shadow copy of every channel's state.
- Guarantees s and r are never asserted together on any channel, so the invalid 2'b11 condition can never be driven.

Parameters:
- N_CH, 4, number of driven channels (>=1); local IDX_W = max(1, clog2(N_CH)).
- PULSE_W, 4, cycles each s/r/en pulse is held high (>=1).
- GAP_W, 2, idle cycles after a pulse before the next command is accepted (>=0).
- SKIP_REDUNDANT, 1, when 1 a command matching the shadow state is acknowledged without pulsing.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  block can accept a command this cycle.
- cmd_idx  input  IDX_W  target channel.
- cmd_set  input  1  1 = set channel, 0 = clear channel.
- s_o  output  N_CH  per-channel set pulse.
- r_o  output  N_CH  per-channel reset pulse.
- en_o  output  N_CH  per-channel enable, high exactly while that channel's s_o or r_o is high.
- shadow_o  output  N_CH  believed state of each channel.
- busy  output  1  state != IDLE.
- done  output  1  one-cycle completion strobe.
- err  output  1  one-cycle strobe for an out-of-range index.

Behaviour:
- Clock and reset
  - Single clock domain; reset is synchronous and active-high.
  - Reset has priority over all other activity.
- Reset values
  - s_o, r_o, en_o, shadow_o = 0.
  - busy, done, err = 0.
  - State = IDLE, so cmd_ready = 1 in the first cycle after reset deasserts.
- Outputs
  - All outputs are registered.
  - cmd_ready is decoded from the state register only: 1 iff IDLE.
- Handshake
  - A command is accepted on a rising edge where cmd_valid & cmd_ready.
  - cmd_idx and cmd_set are sampled only on that edge.
  - cmd_valid is ignored while not ready; no queuing.
- FSM states: IDLE, PULSE, GAP.
- IDLE, on acceptance:
  - cmd_idx >= N_CH: err = 1 for the next cycle; no pulse; shadow unchanged; stay IDLE.
  - SKIP_REDUNDANT = 1 and shadow_o[cmd_idx] == cmd_set: done = 1 for the next cycle; no pulse; stay IDLE.
  - Otherwise: go to PULSE, load the counter with PULSE_W-1, and set shadow_o[cmd_idx] = cmd_set on the same edge.
    - cmd_set = 1: s_o[idx] = 1 and en_o[idx] = 1.
    - cmd_set = 0: r_o[idx] = 1 and en_o[idx] = 1.
    - All other channels stay at 0.
- PULSE
  - Pulse bits are held for exactly PULSE_W cycles, starting the cycle after acceptance.
  - When the counter reaches 0, all s_o/r_o/en_o bits clear on the next edge.
  - Next state is GAP with the counter loaded to GAP_W-1, or IDLE if GAP_W = 0.
- GAP
  - All pulse outputs are 0; the counter decrements.
  - At counter 0, go to IDLE.
- done timing
  - done = 1 in the first IDLE cycle following GAP, or following PULSE when GAP_W = 0.
  - A command may be accepted in that same cycle (back-to-back).
- Accept-to-accept spacing for pulsed commands is PULSE_W+GAP_W+1 cycles.
- Counter is sized for max(PULSE_W, GAP_W, 1); no wrap occurs.
- Invariants
  - s_o & r_o == 0 at all times.
  - At most one bit of en_o is set.
  - en_o == s_o | r_o.
- Reset mid-PULSE or mid-GAP
  - Aborts the operation: all outputs return to their reset values on that edge.
  - No done is produced.
  - shadow_o clears to 0.
- err and done are never asserted in the same cycle.
- busy = 1 in PULSE and GAP.

Test Plan:
- Reset, then idle for 3 cycles -> cmd_ready = 1, shadow_o = 4'b0000, busy = 0, all pulse outputs 0.
- Accept idx = 2, set = 1 (PULSE_W = 4, GAP_W = 2) -> s_o = 4'b0100 and en_o = 4'b0100 for exactly 4 cycles, r_o = 0, then 2 gap cycles, done = 1 seven cycles after acceptance; shadow_o = 4'b0100 from the cycle after acceptance.
- Repeat idx = 2, set = 1 -> no pulse, done = 1 on the next cycle, busy stays 0; with SKIP_REDUNDANT = 0 the full 4-cycle pulse is produced.
- N_CH = 3, accept idx = 3 -> err = 1 for one cycle, done = 0, shadow_o unchanged, s_o/r_o stay 0.
- Hold cmd_valid high with idx 0 set, idx 0 clear, idx 1 set -> three non-overlapping pulses, each accepted in its done cycle, spacing 7 cycles; s_o & r_o == 0 checked every cycle.
- Assert reset in the 2nd PULSE cycle of idx = 1, clear -> next cycle r_o = 0, en_o = 0, shadow_o = 0, no done, cmd_ready = 1 once reset drops.
